// File: rtl/reflect8n.sv
// reflect8n: registered bit-reflection of the low N bytes of a 64-bit word.
// N = bytewidth + 1. Bits above 8N are ignored on input and cleared on output.
// One cycle of latency, full throughput, no combinational input-to-output path.
module reflect8n (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [63:0] value,
    input  logic [2:0]  bytewidth,
    output logic        out_valid,
    output logic [63:0] reflected_value
);

    // One fully reflected candidate per legal byte count; bytewidth selects one.
    logic [7:0][63:0] cand;

    logic [63:0] reflected_d;
    logic [63:0] reflected_q;
    logic        valid_d;
    logic        valid_q;

    genvar n, i;
    for (n = 0; n < 8; n++) begin : g_width
        localparam int W = 8 * (n + 1);
        for (i = 0; i < 64; i++) begin : g_bit
            if (i < W) begin : g_in
                assign cand[n][i] = value[W-1-i];
            end else begin : g_zero
                assign cand[n][i] = 1'b0;
            end
        end
    end

    // Next state: load the selected reflection on a valid cycle, otherwise hold.
    always_comb begin
        valid_d     = in_valid;
        reflected_d = reflected_q;
        if (in_valid) begin
            reflected_d = cand[bytewidth];
        end
    end

    // Output register; reset clears both outputs immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q     <= 1'b0;
            reflected_q <= 64'h0;
        end else begin
            valid_q     <= valid_d;
            reflected_q <= reflected_d;
        end
    end

    assign out_valid       = valid_q;
    assign reflected_value = reflected_q;

endmodule

// File: tb/tb_reflect8n.sv
// Directed and random checks for reflect8n.
module tb_reflect8n;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [63:0] value;
    logic [2:0]  bytewidth;
    logic        out_valid;
    logic [63:0] reflected_value;

    int n_checks;
    int n_pass;

    reflect8n dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .value           (value),
        .bytewidth       (bytewidth),
        .out_valid       (out_valid),
        .reflected_value (reflected_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] bitrev8(input logic [7:0] b);
        logic [7:0] r;
        for (int k = 0; k < 8; k++) r[k] = b[7-k];
        return r;
    endfunction

    // Byte-oriented reference: reverse byte order over N bytes, bit-reverse each byte.
    function automatic logic [63:0] model(input logic [63:0] v, input logic [2:0] bw);
        logic [63:0] r;
        int nb;
        r  = 64'h0;
        nb = int'(bw) + 1;
        for (int b = 0; b < nb; b++) r[8*b +: 8] = bitrev8(v[8*(nb-1-b) +: 8]);
        return r;
    endfunction

    function automatic logic [63:0] mask_w(input logic [63:0] v, input logic [2:0] bw);
        logic [63:0] r;
        r = 64'h0;
        for (int b = 0; b <= int'(bw); b++) r[8*b +: 8] = v[8*b +: 8];
        return r;
    endfunction

    task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    // Drive one cycle of input at the falling edge, then sample after the rising edge.
    task automatic apply(input logic [63:0] v, input logic [2:0] bw, input logic vld);
        @(negedge clk);
        value     = v;
        bytewidth = bw;
        in_valid  = vld;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0] v;
        logic [63:0] r;
        logic [2:0]  bw;
        logic [63:0] tv [4];
        logic [2:0]  tb [4];
        logic [63:0] last;

        n_checks  = 0;
        n_pass    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        value     = 64'h0;
        bytewidth = 3'd0;

        #12;
        check1 ("reset_valid", out_valid, 1'b0);
        check64("reset_data", reflected_value, 64'h0);
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors
        apply(64'h01, 3'd0, 1'b1);
        check64("bw0_01", reflected_value, 64'h80);
        check1 ("bw0_01_vld", out_valid, 1'b1);
        apply(64'hFFFF_FFFF_FFFF_FF01, 3'd0, 1'b1);
        check64("bw0_upper", reflected_value, 64'h80);
        apply(64'h1234, 3'd1, 1'b1);
        check64("bw1_1234", reflected_value, 64'h2C48);
        apply(64'hFFFF_FFFF_0000_0001, 3'd3, 1'b1);
        check64("bw3_upper", reflected_value, 64'h8000_0000);
        apply(64'h0123_4567_89AB_CDEF, 3'd7, 1'b1);
        check64("bw7_pattern", reflected_value, 64'hF7B3_D591_E6A2_C480);
        apply(64'h1, 3'd7, 1'b1);
        check64("bw7_one", reflected_value, 64'h8000_0000_0000_0000);

        // Gap: out_valid drops, data holds even though inputs change
        apply(64'hDEAD_BEEF_DEAD_BEEF, 3'd5, 1'b0);
        check1 ("gap_vld", out_valid, 1'b0);
        check64("gap_hold", reflected_value, 64'h8000_0000_0000_0000);

        // Back-to-back with differing widths
        tv[0] = 64'h0000_0000_00A5_C3F0; tb[0] = 3'd2;
        tv[1] = 64'h1122_3344_5566_7788; tb[1] = 3'd7;
        tv[2] = 64'h0000_00F0_0F0F_1234; tb[2] = 3'd4;
        tv[3] = 64'hFFFF_FFFF_FFFF_0080; tb[3] = 3'd1;
        for (int k = 0; k < 4; k++) begin
            apply(tv[k], tb[k], 1'b1);
            check64($sformatf("b2b_data%0d", k), reflected_value, model(tv[k], tb[k]));
            check1 ($sformatf("b2b_vld%0d", k), out_valid, 1'b1);
        end
        last = model(tv[3], tb[3]);
        apply(64'h0, 3'd0, 1'b0);
        check1 ("b2b_gap_vld", out_valid, 1'b0);
        check64("b2b_gap_hold", reflected_value, last);

        // Asynchronous reset mid-stream while out_valid is high
        apply(64'h0123_4567_89AB_CDEF, 3'd6, 1'b1);
        check1 ("pre_rst_vld", out_valid, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check1 ("async_rst_vld", out_valid, 1'b0);
        check64("async_rst_data", reflected_value, 64'h0);
        apply(64'hFFFF_FFFF_FFFF_FFFF, 3'd7, 1'b1);
        check1 ("rst_held_vld", out_valid, 1'b0);
        check64("rst_held_data", reflected_value, 64'h0);
        @(negedge clk);
        rst       = 1'b0;
        value     = 64'h0000_0000_0000_00F0;
        bytewidth = 3'd0;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        check1 ("post_rst_vld", out_valid, 1'b1);
        check64("post_rst_data", reflected_value, 64'h0F);

        // Random sweep with involution check
        for (int k = 0; k < 10000; k++) begin
            v  = {$urandom, $urandom};
            bw = 3'($urandom_range(7));
            apply(v, bw, 1'b1);
            r = reflected_value;
            check64("rand_fwd", r, model(v, bw));
            apply(r, bw, 1'b1);
            check64("rand_invol", reflected_value, mask_w(v, bw));
        end

        in_valid = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
